alarm_zone_ctrl: RTL
====================

// Module: alarm_zone_ctrl
// PURPOSE
// - Multi-zone intrusion alarm controller with parametrised zone count, keypad width, codes and timers.
// - Adds exit delay, per-zone bypass mask, first-trip zone latching, arm rejection and timed siren with alarm memory.
// - Sits between debounced sensor/keypad logic and the siren/status LED drivers; all activity gated by ena.
// PARAMETERS
// - NUM_ZONES    4        number of sensor zones (1..16)
// - KEY_W        4        keypad code width
// - ARM_CODE     4'b0011  code that arms (KEY_W bits; must differ from DISARM_CODE)
// - DISARM_CODE  4'b1100  code that disarms
// - EXIT_DELAY   50       ena-cycles spent in EXIT_WAIT (>=1)
// - ENTRY_DELAY  100      ena-cycles spent in ENTRY_WAIT (>=1)
// - SIREN_TIME   200      ena-cycles siren sounds in ALARM (>=1)
// - CNT_W = $clog2(max(EXIT_DELAY,ENTRY_DELAY,SIREN_TIME)+1), localparam
// PORTS
// - clk           in   1          clock, all logic on posedge
// - reset_n       in   1          synchronous, active-low reset; takes effect only when ena=1
// - ena           in   1          clock enable; ena=0 freezes all state, counter and outputs
// - zone_in       in   NUM_ZONES  sensor level per zone, 1 = open/tripped
// - zone_mask     in   NUM_ZONES  1 = zone bypassed (ignored everywhere)
// - keypad        in   KEY_W      entered code, sampled only when key_valid=1
// - key_valid     in   1          keypad strobe; code acted on in that ena cycle only
// - alarm_siren   out  1          siren drive
// - is_armed      out  1          state == ARMED
// - is_exit_delay out  1          state == EXIT_WAIT
// - is_wait_delay out  1          state == ENTRY_WAIT
// - alarm_memory  out  1          state == ALARM_MEM (alarm occurred, siren timed out)
// - arm_reject    out  1          one-ena-cycle pulse: arm refused
// - zone_latched  out  NUM_ZONES  zones that tripped since last arm
// BEHAVIOUR
// - trip = |(zone_in & ~zone_mask); dis = key_valid && keypad==DISARM_CODE; arm = key_valid && keypad==ARM_CODE.
// - Reset (reset_n=0, ena=1): state DISARMED, counter 0, every output 0, zone_latched 0.
// - Outputs are registered Moore decodes of the current state: a flag asserts one ena-cycle after the state is entered.
// - DISARMED: arm && !trip -> EXIT_WAIT, counter<=EXIT_DELAY-1, zone_latched<=0; arm && trip -> stay, arm_reject=1 next cycle.
// - EXIT_WAIT: zones ignored; dis -> DISARMED; else counter==0 -> ARMED; else counter-1.
// - ARMED: dis -> DISARMED (dis wins over simultaneous trip); trip -> ENTRY_WAIT, counter<=ENTRY_DELAY-1, latch tripped zones.
// - ENTRY_WAIT: dis -> DISARMED (dis wins over counter==0); counter==0 -> ALARM, counter<=SIREN_TIME-1; else counter-1.
// - ENTRY_WAIT/ALARM: newly tripped unmasked zones OR-ed into zone_latched every cycle.
// - ALARM: siren on; dis -> DISARMED; counter==0 -> ALARM_MEM; else counter-1.
// - ALARM_MEM: siren off, alarm_memory=1; dis -> DISARMED; no re-trigger.
// - zone_latched holds its value through DISARMED; cleared only by reset or accepted arm.
// - Counter is 0 in DISARMED, ARMED, ALARM_MEM; reaching zero holds (no wrap below 0).
// - Dwell: EXIT_WAIT lasts exactly EXIT_DELAY, ENTRY_WAIT ENTRY_DELAY, ALARM SIREN_TIME ena-cycles.
// - arm in any state other than DISARMED is ignored; dis in DISARMED is ignored.
// - Mid-operation reset returns to DISARMED on that ena-cycle regardless of state or counter.
// CONFIGURATION
// - TAMPER_EN defined: adds input port tamper (1 bit). tamper=1 in ANY state (including DISARMED, EXIT_WAIT)
//   forces ALARM with counter<=SIREN_TIME-1; tamper beats dis; while tamper held in ALARM, counter reloads (siren continuous).
// - TAMPER_EN undefined: no tamper port; ALARM reachable only via ENTRY_WAIT timeout.
// TESTING (bench params: NUM_ZONES=4, EXIT_DELAY=3, ENTRY_DELAY=4, SIREN_TIME=5, ena=1 unless stated)
// - Reset: reset_n=0 one cycle -> all outputs 0, zone_latched=4'b0000.
// - Arm/full alarm: arm 4'b0011 -> is_exit_delay 3 cycles, is_armed; zone_in=4'b0100 -> is_wait_delay 4 cycles,
//   alarm_siren 5 cycles, then alarm_memory=1, zone_latched=4'b0100; 4'b1100 -> all flags 0.
// - Arm reject/mask: zone_in=4'b0001, mask=0 -> arm gives arm_reject pulse, stays DISARMED; mask=4'b0001 -> arm accepted.
// - Disarm priority: in ENTRY_WAIT apply 4'b1100 on the cycle counter==0 -> DISARMED, alarm_siren never asserts.
// - ena freeze: in ENTRY_WAIT drop ena 10 cycles -> outputs/counter unchanged; dwell resumes, total 4 ena-cycles.
// - TAMPER_EN: tamper=1 while DISARMED -> alarm_siren next cycles; hold tamper 8 cycles -> siren stays on 8+5 cycles.

Source files
------------

// File: rtl/alarm_zone_ctrl.sv
// Multi-zone intrusion alarm controller: exit/entry delays, bypass mask, zone latching, timed siren.
// Optional tamper input enabled by defining TAMPER_EN.
module alarm_zone_ctrl #(
  parameter int unsigned      NUM_ZONES   = 4,
  parameter int unsigned      KEY_W       = 4,
  parameter logic [KEY_W-1:0] ARM_CODE    = 4'b0011,
  parameter logic [KEY_W-1:0] DISARM_CODE = 4'b1100,
  parameter int unsigned      EXIT_DELAY  = 50,
  parameter int unsigned      ENTRY_DELAY = 100,
  parameter int unsigned      SIREN_TIME  = 200
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ena,
  input  logic [NUM_ZONES-1:0] zone_in,
  input  logic [NUM_ZONES-1:0] zone_mask,
  input  logic [KEY_W-1:0]     keypad,
  input  logic                 key_valid,
`ifdef TAMPER_EN
  input  logic                 tamper,
`endif
  output logic                 alarm_siren,
  output logic                 is_armed,
  output logic                 is_exit_delay,
  output logic                 is_wait_delay,
  output logic                 alarm_memory,
  output logic                 arm_reject,
  output logic [NUM_ZONES-1:0] zone_latched
);

  localparam int unsigned MAX_A = (EXIT_DELAY > ENTRY_DELAY) ? EXIT_DELAY : ENTRY_DELAY;
  localparam int unsigned MAX_D = (MAX_A > SIREN_TIME) ? MAX_A : SIREN_TIME;
  localparam int unsigned CNT_W = $clog2(MAX_D + 1);

  localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(EXIT_DELAY - 1);
  localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_DELAY - 1);
  localparam logic [CNT_W-1:0] SIREN_LD = CNT_W'(SIREN_TIME - 1);

  typedef enum logic [2:0] {
    S_DISARMED,
    S_EXIT,
    S_ARMED,
    S_ENTRY,
    S_ALARM,
    S_MEM
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [NUM_ZONES-1:0] hits;
  logic                 trip;
  logic                 arm;
  logic                 dis;

  assign hits = zone_in & ~zone_mask;
  assign trip = |hits;
  assign arm  = key_valid && (keypad == ARM_CODE);
  assign dis  = key_valid && (keypad == DISARM_CODE);

  // Flags decode the state held before this edge, so each trails its state by one ena-cycle.
  always_ff @(posedge clk) begin
    if (ena) begin
      if (!reset_n) begin
        state         <= S_DISARMED;
        cnt           <= '0;
        alarm_siren   <= 1'b0;
        is_armed      <= 1'b0;
        is_exit_delay <= 1'b0;
        is_wait_delay <= 1'b0;
        alarm_memory  <= 1'b0;
        arm_reject    <= 1'b0;
        zone_latched  <= '0;
      end else begin
        alarm_siren   <= (state == S_ALARM);
        is_armed      <= (state == S_ARMED);
        is_exit_delay <= (state == S_EXIT);
        is_wait_delay <= (state == S_ENTRY);
        alarm_memory  <= (state == S_MEM);
        arm_reject    <= 1'b0;

        if (state == S_ENTRY || state == S_ALARM) begin
          zone_latched <= zone_latched | hits;
        end

        case (state)
          S_DISARMED: begin
            if (arm) begin
              if (!trip) begin
                state        <= S_EXIT;
                cnt          <= EXIT_LD;
                zone_latched <= '0;
              end else begin
                arm_reject <= 1'b1;
              end
            end
          end
          S_EXIT: begin
            if (dis) begin
              state <= S_DISARMED;
              cnt   <= '0;
            end else if (cnt == '0) begin
              state <= S_ARMED;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          S_ARMED: begin
            if (dis) begin
              state <= S_DISARMED;
            end else if (trip) begin
              state        <= S_ENTRY;
              cnt          <= ENTRY_LD;
              zone_latched <= zone_latched | hits;
            end
          end
          S_ENTRY: begin
            if (dis) begin
              state <= S_DISARMED;
              cnt   <= '0;
            end else if (cnt == '0) begin
              state <= S_ALARM;
              cnt   <= SIREN_LD;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          S_ALARM: begin
            if (dis) begin
              state <= S_DISARMED;
              cnt   <= '0;
            end else if (cnt == '0) begin
              state <= S_MEM;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          S_MEM: begin
            if (dis) begin
              state <= S_DISARMED;
            end
          end
          default: begin
            state <= S_DISARMED;
            cnt   <= '0;
          end
        endcase

`ifdef TAMPER_EN
        // Tamper overrides every transition above and keeps the siren timer topped up.
        if (tamper) begin
          state <= S_ALARM;
          cnt   <= SIREN_LD;
        end
`endif
      end
    end
  end

endmodule
